// File: rtl/chip8_fb_engine.sv
// CHIP-8/SCHIP framebuffer: 1bpp dual-port display RAM with a hardware DRW row engine and a clear engine.
// Optional build macro CHIP8_FB_WRAP_EN: sprite pixels past the right edge wrap instead of being clipped.
//
// state   | meaning
// IDLE    | direct CPU access live, waiting for draw_start / clear_start
// CLEAR   | writing 0 to one address per cycle, ascending
// DRAW_RD | reading the pixel under sprite bit i
// DRAW_WR | XOR-ing sprite bit i into the pixel, accumulating collision
// DONE    | one-cycle done pulse, then back to IDLE
module chip8_fb_engine #(
  parameter int FB_W  = 64,
  parameter int FB_H  = 32,
  parameter int SPR_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(FB_W)-1:0]   fb_addr_x,
  input  logic [$clog2(FB_H)-1:0]   fb_addr_y,
  input  logic                      fb_writedata,
  input  logic                      fb_WE,
  output logic                      fb_readdata,
  input  logic                      draw_start,
  input  logic [7:0]                draw_x,
  input  logic [7:0]                draw_y,
  input  logic [SPR_W-1:0]          draw_row,
  input  logic                      clear_start,
  output logic                      busy,
  output logic                      done,
  output logic                      collision,
  input  logic [$clog2(FB_W)-1:0]   vga_addr_x,
  input  logic [$clog2(FB_H)-1:0]   vga_addr_y,
  output logic                      vga_pixel
);
  localparam int XW = $clog2(FB_W);
  localparam int YW = $clog2(FB_H);
  localparam int AW = XW + YW;
  localparam int IW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
`ifdef CHIP8_FB_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_DRAW_RD = 3'd2;
  localparam logic [2:0] S_DRAW_WR = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state;
  logic             mem [0:FB_W*FB_H-1];
  logic [XW-1:0]    x0;
  logic [YW-1:0]    y0;
  logic [SPR_W-1:0] row_sh;
  logic [IW-1:0]    pix_i;
  logic [AW-1:0]    clr_addr;
  logic             draw_q;
  logic [XW:0]      col_sum;
  logic             col_ok;
  logic [AW-1:0]    addr_a;
  logic             we_a;
  logic             wd_a;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // The carry bit of col_sum marks a pixel that ran off the right edge.
  always_comb begin
    col_sum = {1'b0, x0} + (XW+1)'(pix_i);
    col_ok  = WRAP | ~col_sum[XW];
    addr_a  = {fb_addr_y, fb_addr_x};
    we_a    = 1'b0;
    wd_a    = fb_writedata;
    case (state)
      S_IDLE: we_a = fb_WE;
      S_CLEAR: begin
        addr_a = clr_addr;
        we_a   = 1'b1;
        wd_a   = 1'b0;
      end
      S_DRAW_RD: addr_a = {y0, col_sum[XW-1:0]};
      S_DRAW_WR: begin
        addr_a = {y0, col_sum[XW-1:0]};
        we_a   = row_sh[SPR_W-1] & col_ok;
        wd_a   = ~draw_q;
      end
      default: ;
    endcase
    if (reset) we_a = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wd_a;
    draw_q <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (reset) vga_pixel <= 1'b0;
    else       vga_pixel <= mem[{vga_addr_y, vga_addr_x}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      collision   <= 1'b0;
      fb_readdata <= 1'b0;
      x0          <= '0;
      y0          <= '0;
      row_sh      <= '0;
      pix_i       <= '0;
      clr_addr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          fb_readdata <= mem[addr_a];
          if (clear_start) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end else if (draw_start) begin
            state     <= S_DRAW_RD;
            x0        <= XW'(draw_x & 8'(FB_W - 1));
            y0        <= YW'(draw_y & 8'(FB_H - 1));
            row_sh    <= draw_row;
            pix_i     <= '0;
            collision <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_addr == {AW{1'b1}}) state <= S_DONE;
          else                        clr_addr <= clr_addr + AW'(1);
        end
        S_DRAW_RD: state <= S_DRAW_WR;
        S_DRAW_WR: begin
          if (row_sh[SPR_W-1] && col_ok && draw_q) collision <= 1'b1;
          row_sh <= row_sh << 1;
          if (pix_i == IW'(SPR_W - 1)) begin
            state <= S_DONE;
          end else begin
            pix_i <= pix_i + IW'(1);
            state <= S_DRAW_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
